aclk_setup_ctrl: RTL and testbench
==================================

Name: aclk_setup_ctrl

Overview:
- Keypad-driven setup controller for the alarm clock; sequences loading of the alarm register and the current-time counter.
- Collects up to four BCD digits from a debounced keypad into an entry buffer and validates them as HH:MM.
- Issues a one-cycle load strobe to the alarm register (load_new_a) or the time counter (load_new_c), and drives display-select flags.
- Sits between the keypad scanner and the alarm-register, counter and display-mux blocks.

Parameters:
- TIMEOUT_SEC, 10: one_second ticks without a key press before ENTRY aborts.
- SHOW_SEC, 5: one_second ticks the alarm time stays displayed in SHOW_ALARM.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- one_second  input  1  single-cycle tick, once per second.
- key_valid  input  1  single-cycle strobe, one per debounced key press.
- key  input  4  key code, valid when key_valid=1. Codes: 0-9 digit, 10 ALARM, 11 TIME, 12-15 ignored.
- new_ms_hr, new_ls_hr, new_ms_min, new_ls_min  output  4 each  entry buffer; feeds new_alarm_* and new_current_*.
- load_new_a  output  1  one-cycle strobe to the alarm register.
- load_new_c  output  1  one-cycle strobe to the time counter.
- show_new_time  output  1  display shows the entry buffer.
- show_a  output  1  display shows the stored alarm time.
- entry_err  output  1  one-cycle strobe when a commit is rejected.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. Every output is registered.
- Reset values: all outputs 0, buffer 0000, digit count 0, timer 0, state IDLE. reset mid-entry discards the buffer, and no strobe is issued.
- States: IDLE, ENTRY, SHOW_ALARM.
- IDLE, digit key:
  - Clear buffer, shift digit into ls_min, digit count 1, timer 0.
  - Go to ENTRY; show_new_time=1 from the next cycle.
- IDLE, ALARM key: go to SHOW_ALARM, show_a=1, timer 0.
- IDLE, TIME key or codes 12-15: no effect.
- ENTRY, digit key:
  - Shift left: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=digit.
  - Count saturates at 4. Digits after the 4th keep shifting, so the last four digits win. Timer 0.
- ENTRY, ALARM or TIME key: commit check. Valid requires all of:
  - count==4;
  - hours<=23 (ms_hr<=2, and ls_hr<=3 when ms_hr==2);
  - ms_min<=5;
  - ls_min<=9.
- Commit outcomes (key sampled at cycle N):
  - Valid + ALARM: load_new_a=1 at cycle N+1 only.
  - Valid + TIME: load_new_c=1 at cycle N+1 only.
  - Invalid: entry_err=1 at cycle N+1, no load.
  - In all cases: buffer is held stable through N+1, state returns to IDLE, and show_new_time drops at N+1.
- ENTRY timeout: on each one_second, timer+1. When timer reaches TIMEOUT_SEC: go to IDLE, clear buffer, no strobe, no error.
- SHOW_ALARM: one_second increments the timer. At SHOW_SEC, or on any key_valid (key consumed), return to IDLE with show_a=0.
- Simultaneous key_valid and one_second: the key wins and the timer is cleared.
- load_new_a and load_new_c are never both high. At most one strobe is issued per key press.
- Width rules: timer is clog2(max(TIMEOUT_SEC, SHOW_SEC)+1) bits. Digit values 0-9 are stored unmodified.

Decomposition:
- Shared header aclk_defs.vh: key code constants (KEY_ALARM=10, KEY_TIME=11), state encodings, BCD limits (23, 59).
- One sub-module, aclk_keyreg: 4-digit shift buffer with clear/shift controls, synchronous reset. The FSM, timer and validation stay in aclk_setup_ctrl.

Test Plan:
- Enter keys 0,7,3,0 then ALARM -> buffer 0730; load_new_a=1 for exactly one cycle, one cycle after the ALARM strobe; load_new_c stays 0; state returns to IDLE.
- Enter 2,3,5,9 then TIME -> load_new_c pulse with buffer 2359. Then enter 2,4,0,0 then TIME -> entry_err pulse, no load.
- Enter 1,2,3,4,5 then ALARM -> buffer 2345, load_new_a pulse. Enter 1,2 then ALARM -> entry_err (count<4).
- Enter 1, then 10 one_second ticks with no keys -> return to IDLE, buffer 0000, show_new_time 0, no strobes. Also check a key coinciding with the 9th tick restarts the timeout.
- ALARM from IDLE -> show_a=1 for 5 ticks, then 0. Repeat, pressing digit 4 after 2 ticks -> show_a drops next cycle and no entry starts.
- reset asserted one cycle after the 3rd digit -> all outputs 0 the next cycle; a following ALARM key produces no load.

Source files
------------

// File: rtl/aclk_setup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aclk_setup_ctrl_pkg
// Description : Shared definitions for the alarm-clock setup controller:
//               keypad command codes, FSM state encoding, BCD limits and the
//               HH:MM validity check used at commit time.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aclk_setup_ctrl_pkg;

    // Keypad command codes (0-9 are digits, 12-15 are ignored)
    localparam logic [3:0] KEY_ALARM = 4'd10;
    localparam logic [3:0] KEY_TIME  = 4'd11;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    // BCD limits for a 24-hour HH:MM value (23:59)
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam logic [3:0] MS_HR_MAX     = 4'd2;
    localparam logic [3:0] LS_HR_MAX_AT2 = 4'd3;
    localparam logic [3:0] MS_MIN_MAX    = 4'd5;
    localparam logic [3:0] LS_MIN_MAX    = 4'd9;

    // Number of digits a complete entry holds
    localparam logic [2:0] DIGITS_FULL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= KEY_DIGIT_MAX);
    endfunction

    // Digit-wise form of "HH <= 23 and MM <= 59" for BCD digits 0-9
    function automatic logic hhmm_valid(input logic [3:0] ms_hr,
                                        input logic [3:0] ls_hr,
                                        input logic [3:0] ms_min,
                                        input logic [3:0] ls_min);
        logic hr_ok;
        hr_ok = (ms_hr < MS_HR_MAX) ||
                ((ms_hr == MS_HR_MAX) && (ls_hr <= LS_HR_MAX_AT2));
        return hr_ok && (ms_min <= MS_MIN_MAX) && (ls_min <= LS_MIN_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_setup_ctrl_keyreg.sv
`default_nettype none
// ============================================================================
// Module      : aclk_setup_ctrl_keyreg
// Description : Four-digit entry buffer. A shift moves every digit one place
//               towards ms_hr and inserts the new digit at ls_min. clear and
//               shift together start a fresh entry with a single digit.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               clear_i, shift_i  - buffer controls
//               digit_i           - digit shifted in
//               ms_hr_o .. ls_min_o - registered buffer contents
// Revision    : 1.0 - initial release
// ============================================================================
module aclk_setup_ctrl_keyreg (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic [3:0] digit_i,
    output logic [3:0] ms_hr_o,
    output logic [3:0] ls_hr_o,
    output logic [3:0] ms_min_o,
    output logic [3:0] ls_min_o
);

    logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= 4'd0;
        end else if (clear_i) begin
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= shift_i ? digit_i : 4'd0;
        end else if (shift_i) begin
            ms_hr_q  <= ls_hr_q;
            ls_hr_q  <= ms_min_q;
            ms_min_q <= ls_min_q;
            ls_min_q <= digit_i;
        end
    end

    assign ms_hr_o  = ms_hr_q;
    assign ls_hr_o  = ls_hr_q;
    assign ms_min_o = ms_min_q;
    assign ls_min_o = ls_min_q;

endmodule
`default_nettype wire

// File: rtl/aclk_setup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aclk_setup_ctrl
// Description : Keypad-driven setup controller for the alarm clock. Collects
//               up to four BCD digits, validates them as HH:MM on an ALARM or
//               TIME key and issues a one-cycle load strobe (or an error
//               strobe). Also sequences the timed alarm-display mode.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               one_second          - 1 Hz single-cycle tick
//               key_valid, key      - debounced key strobe and code
//               new_ms_hr..new_ls_min - entry buffer
//               load_new_a/c        - alarm / time-counter load strobes
//               show_new_time       - display shows the entry buffer
//               show_a              - display shows the stored alarm
//               entry_err           - rejected commit strobe
// Revision    : 1.0 - initial release
// ============================================================================
module aclk_setup_ctrl #(
    parameter int TIMEOUT_SEC = 10,
    parameter int SHOW_SEC    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_new_time,
    output logic       show_a,
    output logic       entry_err
);

    import aclk_setup_ctrl_pkg::*;

    localparam int TMAX = (TIMEOUT_SEC > SHOW_SEC) ? TIMEOUT_SEC : SHOW_SEC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_SEC);
    localparam logic [TW-1:0] SHOW_LIM    = TW'(SHOW_SEC);

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    count_q;
    logic          load_a_q, load_c_q, err_q, show_new_q, show_a_q;

    logic          w_key_digit, w_key_cmd, w_commit_ok, w_timeout;
    logic          w_buf_clear, w_buf_shift;
    logic [TW-1:0] w_timer_inc;

    assign w_key_digit = key_valid && is_digit(key);
    assign w_key_cmd   = key_valid && ((key == KEY_ALARM) || (key == KEY_TIME));
    assign w_timer_inc = timer_q + TW'(1);

    // A tick only counts in ENTRY when no digit/command key arrives with it;
    // ignored key codes do not mask the tick.
    assign w_timeout = (state_q == ST_ENTRY) && !w_key_digit && !w_key_cmd &&
                       one_second && (w_timer_inc == TIMEOUT_LIM);

    assign w_commit_ok = (count_q == DIGITS_FULL) &&
                         hhmm_valid(new_ms_hr, new_ls_hr, new_ms_min, new_ls_min);

    assign w_buf_clear = ((state_q == ST_IDLE) && w_key_digit) || w_timeout;
    assign w_buf_shift = w_key_digit &&
                         ((state_q == ST_IDLE) || (state_q == ST_ENTRY));

    aclk_setup_ctrl_keyreg u_keyreg (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (w_buf_clear),
        .shift_i  (w_buf_shift),
        .digit_i  (key),
        .ms_hr_o  (new_ms_hr),
        .ls_hr_o  (new_ls_hr),
        .ms_min_o (new_ms_min),
        .ls_min_o (new_ls_min)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            count_q    <= 3'd0;
            load_a_q   <= 1'b0;
            load_c_q   <= 1'b0;
            err_q      <= 1'b0;
            show_new_q <= 1'b0;
            show_a_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle by construction
            load_a_q <= 1'b0;
            load_c_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_key_digit) begin
                        state_q    <= ST_ENTRY;
                        count_q    <= 3'd1;
                        timer_q    <= '0;
                        show_new_q <= 1'b1;
                    end else if (key_valid && (key == KEY_ALARM)) begin
                        state_q  <= ST_SHOW;
                        timer_q  <= '0;
                        show_a_q <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (w_key_digit) begin
                        // Saturating count: later digits keep shifting
                        if (count_q != DIGITS_FULL)
                            count_q <= count_q + 3'd1;
                        timer_q <= '0;
                    end else if (w_key_cmd) begin
                        if (!w_commit_ok)
                            err_q <= 1'b1;
                        else if (key == KEY_ALARM)
                            load_a_q <= 1'b1;
                        else
                            load_c_q <= 1'b1;
                        state_q    <= ST_IDLE;
                        count_q    <= 3'd0;
                        timer_q    <= '0;
                        show_new_q <= 1'b0;
                    end else if (one_second) begin
                        if (w_timeout) begin
                            state_q    <= ST_IDLE;
                            count_q    <= 3'd0;
                            timer_q    <= '0;
                            show_new_q <= 1'b0;
                        end else begin
                            timer_q <= w_timer_inc;
                        end
                    end
                end
                ST_SHOW: begin
                    // Any key leaves the alarm display and is consumed
                    if (key_valid) begin
                        state_q  <= ST_IDLE;
                        timer_q  <= '0;
                        show_a_q <= 1'b0;
                    end else if (one_second) begin
                        if (w_timer_inc == SHOW_LIM) begin
                            state_q  <= ST_IDLE;
                            timer_q  <= '0;
                            show_a_q <= 1'b0;
                        end else begin
                            timer_q <= w_timer_inc;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    timer_q    <= '0;
                    count_q    <= 3'd0;
                    show_new_q <= 1'b0;
                    show_a_q   <= 1'b0;
                end
            endcase
        end
    end

    assign load_new_a    = load_a_q;
    assign load_new_c    = load_c_q;
    assign entry_err     = err_q;
    assign show_new_time = show_new_q;
    assign show_a        = show_a_q;

endmodule
`default_nettype wire

// File: tb/tb_aclk_setup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aclk_setup_ctrl
// Description : Self-checking bench for aclk_setup_ctrl. A behavioural model
//               (digit array, integer HH/MM arithmetic) predicts every output
//               each cycle; directed literal checks pin both DUT and model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aclk_setup_ctrl;

    localparam int TO = 10;
    localparam int SH = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
    logic       load_new_a, load_new_c, show_new_time, show_a, entry_err;

    always #5 clk = ~clk;

    aclk_setup_ctrl #(.TIMEOUT_SEC(TO), .SHOW_SEC(SH)) dut (
        .clk           (clk),
        .reset         (reset),
        .one_second    (one_second),
        .key_valid     (key_valid),
        .key           (key),
        .new_ms_hr     (new_ms_hr),
        .new_ls_hr     (new_ls_hr),
        .new_ms_min    (new_ms_min),
        .new_ls_min    (new_ls_min),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .show_new_time (show_new_time),
        .show_a        (show_a),
        .entry_err     (entry_err)
    );

    wire [15:0] dut_buf = {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 collecting digits, 2 showing alarm
    int md[4];
    int mcnt = 0, msecs = 0, mmode = 0, hh, mm;
    bit m_la = 0, m_lc = 0, m_err = 0, m_snt = 0, m_sa = 0;

    function automatic logic [15:0] m_buf();
        return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
    endfunction

    initial for (int i = 0; i < 4; i++) md[i] = 0;

    always @(posedge clk) begin
        m_la = 0; m_lc = 0; m_err = 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) md[i] = 0;
            mcnt = 0; msecs = 0; mmode = 0; m_snt = 0; m_sa = 0;
        end else if (mmode == 0) begin
            if (key_valid && key <= 9) begin
                md[0] = 0; md[1] = 0; md[2] = 0; md[3] = int'(key);
                mcnt = 1; msecs = 0; mmode = 1; m_snt = 1;
            end else if (key_valid && key == 10) begin
                mmode = 2; m_sa = 1; msecs = 0;
            end
        end else if (mmode == 1) begin
            if (key_valid && key <= 9) begin
                for (int i = 0; i < 3; i++) md[i] = md[i+1];
                md[3] = int'(key);
                if (mcnt < 4) mcnt++;
                msecs = 0;
            end else if (key_valid && (key == 10 || key == 11)) begin
                hh = md[0] * 10 + md[1];
                mm = md[2] * 10 + md[3];
                if (mcnt == 4 && hh <= 23 && mm <= 59) begin
                    if (key == 10) m_la = 1; else m_lc = 1;
                end else begin
                    m_err = 1;
                end
                mmode = 0; m_snt = 0; mcnt = 0; msecs = 0;
            end else if (one_second) begin
                msecs++;
                if (msecs == TO) begin
                    for (int i = 0; i < 4; i++) md[i] = 0;
                    mmode = 0; m_snt = 0; mcnt = 0; msecs = 0;
                end
            end
        end else begin
            if (key_valid) begin
                mmode = 0; m_sa = 0; msecs = 0;
            end else if (one_second) begin
                msecs++;
                if (msecs == SH) begin
                    mmode = 0; m_sa = 0; msecs = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("buffer",        dut_buf,              m_buf());
            chk("load_new_a",    {15'd0, load_new_a},    {15'd0, m_la});
            chk("load_new_c",    {15'd0, load_new_c},    {15'd0, m_lc});
            chk("entry_err",     {15'd0, entry_err},     {15'd0, m_err});
            chk("show_new_time", {15'd0, show_new_time}, {15'd0, m_snt});
            chk("show_a",        {15'd0, show_a},        {15'd0, m_sa});
            chk("loads_exclusive", {15'd0, load_new_a & load_new_c}, 16'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic kv, input logic [3:0] k, input logic t);
        key_valid  = kv;
        key        = k;
        one_second = t;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        one_second = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        cyc(1'b1, k, 1'b0);
    endtask

    task automatic gap();
        cyc(1'b0, 4'd0, 1'b0);
    endtask

    task automatic enter4(input logic [3:0] a, b, c, d);
        press(a); gap(); press(b); gap(); press(c); gap(); press(d); gap();
    endtask

    // Literal check of a DUT output and of the model's prediction for it
    task automatic lit(input string nm, input logic [15:0] act,
                       input logic [15:0] mdl, input logic [15:0] exp);
        chk(nm, act, exp);
        chk({nm, "_model"}, mdl, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        started = 1'b1;
        lit("rst_buf", dut_buf, m_buf(), 16'h0000);
        lit("rst_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);
        lit("rst_sa",  {15'd0, show_a},        {15'd0, m_sa},  16'd0);

        // Ignored code in IDLE
        press(4'd13);
        lit("ign_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);

        // 07:30 -> alarm
        enter4(4'd0, 4'd7, 4'd3, 4'd0);
        lit("a0730_buf", dut_buf, m_buf(), 16'h0730);
        lit("a0730_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd1);
        press(4'd10);
        lit("a0730_la",   {15'd0, load_new_a}, {15'd0, m_la}, 16'd1);
        lit("a0730_lc",   {15'd0, load_new_c}, {15'd0, m_lc}, 16'd0);
        lit("a0730_hold", dut_buf, m_buf(), 16'h0730);
        lit("a0730_snt0", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);
        gap();
        lit("a0730_la_end", {15'd0, load_new_a}, {15'd0, m_la}, 16'd0);

        // 23:59 -> time; 24:00 -> error
        enter4(4'd2, 4'd3, 4'd5, 4'd9);
        press(4'd11);
        lit("t2359_lc",  {15'd0, load_new_c}, {15'd0, m_lc}, 16'd1);
        lit("t2359_buf", dut_buf, m_buf(), 16'h2359);
        gap();
        enter4(4'd2, 4'd4, 4'd0, 4'd0);
        press(4'd11);
        lit("t2400_err", {15'd0, entry_err},  {15'd0, m_err}, 16'd1);
        lit("t2400_lc",  {15'd0, load_new_c}, {15'd0, m_lc},  16'd0);
        gap();
        lit("t2400_err_end", {15'd0, entry_err}, {15'd0, m_err}, 16'd0);

        // Five digits: last four win
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'd5); gap();
        lit("five_buf", dut_buf, m_buf(), 16'h2345);
        press(4'd10);
        lit("five_la", {15'd0, load_new_a}, {15'd0, m_la}, 16'd1);
        gap();

        // Two digits: rejected for short count
        press(4'd1); gap(); press(4'd2); gap();
        press(4'd10);
        lit("short_err", {15'd0, entry_err},  {15'd0, m_err}, 16'd1);
        lit("short_la",  {15'd0, load_new_a}, {15'd0, m_la},  16'd0);
        lit("short_buf", dut_buf, m_buf(), 16'h0012);
        gap();

        // Timeout after ten idle seconds
        press(4'd1); gap();
        repeat (TO - 1) cyc(1'b0, 4'd0, 1'b1);
        lit("to9_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd1);
        cyc(1'b0, 4'd0, 1'b1);
        lit("to10_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);
        lit("to10_buf", dut_buf, m_buf(), 16'h0000);
        gap();

        // Key on the 9th tick restarts the timeout
        press(4'd1); gap();
        repeat (TO - 2) cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd5, 1'b1);
        repeat (TO - 1) cyc(1'b0, 4'd0, 1'b1);
        lit("rs_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd1);
        lit("rs_buf", dut_buf, m_buf(), 16'h0015);
        cyc(1'b0, 4'd0, 1'b1);
        lit("rs_end_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);
        lit("rs_end_buf", dut_buf, m_buf(), 16'h0000);
        gap();

        // Alarm display for SHOW_SEC ticks
        press(4'd10);
        lit("sa_on", {15'd0, show_a}, {15'd0, m_sa}, 16'd1);
        repeat (SH - 1) cyc(1'b0, 4'd0, 1'b1);
        lit("sa_4", {15'd0, show_a}, {15'd0, m_sa}, 16'd1);
        cyc(1'b0, 4'd0, 1'b1);
        lit("sa_5", {15'd0, show_a}, {15'd0, m_sa}, 16'd0);
        gap();

        // Alarm display cut short by a digit key, which is consumed
        press(4'd10);
        repeat (2) cyc(1'b0, 4'd0, 1'b1);
        press(4'd4);
        lit("sak_sa",  {15'd0, show_a},        {15'd0, m_sa},  16'd0);
        lit("sak_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);
        gap();
        lit("sak_buf", dut_buf, m_buf(), 16'h0000);

        // Reset in the middle of an entry
        press(4'd1); gap(); press(4'd2); gap(); press(4'd3); gap();
        reset = 1'b1;
        gap();
        reset = 1'b0;
        lit("mrst_buf", dut_buf, m_buf(), 16'h0000);
        lit("mrst_snt", {15'd0, show_new_time}, {15'd0, m_snt}, 16'd0);
        press(4'd10);
        lit("mrst_la", {15'd0, load_new_a}, {15'd0, m_la}, 16'd0);
        lit("mrst_sa", {15'd0, show_a},     {15'd0, m_sa}, 16'd1);
        press(4'd4);
        gap(); gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
